uart_rx_control: RTL

//  Receive-side control FSM of the UART. It sits between the RX pin and the bit-timing counter
//  (enable_half/enable_max in, flag out) and consumes that counter's flag to sample the line.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_control.sv | 128 ++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive types and the default bit-timing limits
// for a 50 MHz clock at 115200 baud.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int BAUD_MAX  = 434;
    localparam int BAUD_HALF = 217;

endpackage

// File: rtl/uart_rx_control.sv
// UART receive control: synchronizes rx, sequences start/data/parity/stop against
// an external bit-timing counter, and holds each word behind a valid/ack register.
module uart_rx_control
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 baud_flag,
    output logic                 enable_half,
    output logic                 enable_max,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 overrun
);
    localparam int CNT_W = 4;

    rx_state_e            r_state;
    rx_state_e            w_next;
    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic                 r_armed;
    logic                 r_par_err;
    logic [DATA_BITS-1:0] r_shift;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_parity_error;
    logic                 r_framing_error;
    logic                 r_overrun;
    logic                 w_last_bit;
    logic                 w_commit;

    assign w_last_bit = (r_bit_cnt == CNT_W'(DATA_BITS - 1));
    assign w_commit   = (r_state == STOP) && baud_flag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // State changes out of counting states only on baud_flag, so the counter rests at 0.
    always_comb begin
        w_next      = r_state;
        enable_half = 1'b0;
        enable_max  = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_armed && !r_rx_s) w_next = START;
            end
            START: begin
                enable_half = 1'b1;
                if (baud_flag) w_next = r_rx_s ? IDLE : DATA;
            end
            DATA: begin
                enable_max = 1'b1;
                if (baud_flag && w_last_bit) w_next = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: begin
                enable_max = 1'b1;
                if (baud_flag) w_next = STOP;
            end
            STOP: begin
                enable_max = 1'b1;
                if (baud_flag) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_armed   <= 1'b0;
            r_par_err <= 1'b0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            // A new start is only accepted after IDLE has seen the line high (break guard).
            r_armed   <= (r_state == IDLE) && (r_armed || r_rx_s);
            if (r_state == START && baud_flag)
                r_bit_cnt <= '0;
            if (r_state == DATA && baud_flag) begin
                r_shift   <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
            if (r_state == PARITY && baud_flag)
                r_par_err <= (^r_shift) ^ r_rx_s ^ 1'(PARITY_ODD);
        end
    end

    // A commit on the same edge as rx_ack wins; overrun then only counts an unacked word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_data       <= '0;
            r_rx_valid      <= 1'b0;
            r_parity_error  <= 1'b0;
            r_framing_error <= 1'b0;
            r_overrun       <= 1'b0;
        end else if (w_commit) begin
            r_rx_data       <= r_shift;
            r_rx_valid      <= 1'b1;
            r_parity_error  <= (PARITY_EN != 0) ? r_par_err : 1'b0;
            r_framing_error <= ~r_rx_s;
            r_overrun       <= (r_overrun | r_rx_valid) & ~(rx_ack & r_rx_valid);
        end else if (rx_ack && r_rx_valid) begin
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end
    end

    assign rx_data       = r_rx_data;
    assign rx_valid      = r_rx_valid;
    assign parity_error  = r_parity_error;
    assign framing_error = r_framing_error;
    assign overrun       = r_overrun;

endmodule
